// File: rtl/uart_responder.sv
// CPU-facing 8N1 UART: one holding and one shift register on transmit, one receive register.
// Define UART_LOOPBACK_EN to feed the transmit bit stream into the receiver and hold txd at 1.
module uart_responder #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rdn,
   input  logic       wrn,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       data_ready,
   output logic       tbre,
   output logic       tsre,
   input  logic       rxd,
   output logic       txd
);

   localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   logic       rdn_q, rdn_prev_q, wrn_q, wrn_prev_q;
   logic       wr_fall_d, rd_rise_d, rx_in_d;

   tx_state_e  tx_state_q;
   logic [15:0] tx_cnt_q;
   logic [2:0] tx_bit_q;
   logic [7:0] hold_q, tx_sh_q;
   logic       tbre_q, tsre_q, txd_q;

   rx_state_e  rx_state_q;
   logic [15:0] rx_cnt_q;
   logic [2:0] rx_bit_q;
   logic [7:0] rx_sh_q, rx_data_q;
   logic       ready_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rdn_q      <= 1'b1;
         rdn_prev_q <= 1'b1;
         wrn_q      <= 1'b1;
         wrn_prev_q <= 1'b1;
      end else begin
         rdn_q      <= rdn;
         rdn_prev_q <= rdn_q;
         wrn_q      <= wrn;
         wrn_prev_q <= wrn_q;
      end
   end

   assign wr_fall_d = wrn_prev_q & ~wrn_q;
   assign rd_rise_d = ~rdn_prev_q & rdn_q;

`ifdef UART_LOOPBACK_EN
   assign rx_in_d = txd_q;
   assign txd     = 1'b1;
`else
   logic rxd_s1_q, rxd_s2_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rxd_s1_q <= 1'b1;
         rxd_s2_q <= 1'b1;
      end else begin
         rxd_s1_q <= rxd;
         rxd_s2_q <= rxd_s1_q;
      end
   end

   assign rx_in_d = rxd_s2_q;
   assign txd     = txd_q;
`endif

   // A pending holding byte is loaded from TX_IDLE or straight out of the last stop cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         hold_q     <= '0;
         tx_sh_q    <= '0;
         tbre_q     <= 1'b1;
         tsre_q     <= 1'b1;
         txd_q      <= 1'b1;
      end else begin
         if (wr_fall_d && tbre_q) begin
            hold_q <= data_in;
            tbre_q <= 1'b0;
         end
         case (tx_state_q)
            TX_IDLE: begin
               txd_q <= 1'b1;
               if (!tbre_q) begin
                  tx_sh_q    <= hold_q;
                  tbre_q     <= 1'b1;
                  tsre_q     <= 1'b0;
                  txd_q      <= 1'b0;
                  tx_cnt_q   <= '0;
                  tx_state_q <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt_q == BIT_M1) begin
                  tx_cnt_q   <= '0;
                  tx_bit_q   <= '0;
                  txd_q      <= tx_sh_q[0];
                  tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
                  tx_state_q <= TX_DATA;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 16'd1;
               end
            end
            TX_DATA: begin
               if (tx_cnt_q == BIT_M1) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == 3'd7) begin
                     txd_q      <= 1'b1;
                     tx_state_q <= TX_STOP;
                  end else begin
                     tx_bit_q <= tx_bit_q + 3'd1;
                     txd_q    <= tx_sh_q[0];
                     tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 16'd1;
               end
            end
            TX_STOP: begin
               if (tx_cnt_q == BIT_M1) begin
                  tx_cnt_q <= '0;
                  if (!tbre_q) begin
                     tx_sh_q    <= hold_q;
                     tbre_q     <= 1'b1;
                     txd_q      <= 1'b0;
                     tx_state_q <= TX_START;
                  end else begin
                     tsre_q     <= 1'b1;
                     tx_state_q <= TX_IDLE;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 16'd1;
               end
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   // Completion is written after the read-clear so a byte landing on the same cycle wins.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         ready_q    <= 1'b0;
      end else begin
         if (rd_rise_d) ready_q <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               rx_cnt_q <= '0;
               if (!rx_in_d) rx_state_q <= RX_START;
            end
            RX_START: begin
               if (rx_cnt_q == HALF_M1) begin
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_in_d ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == BIT_M1) begin
                  rx_cnt_q <= '0;
                  rx_sh_q  <= {rx_in_d, rx_sh_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                  else rx_bit_q <= rx_bit_q + 3'd1;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt_q == BIT_M1) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= RX_IDLE;
                  if (rx_in_d) begin
                     rx_data_q <= rx_sh_q;
                     ready_q   <= 1'b1;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + 16'd1;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   assign data_oe    = ~rdn_q;
   assign data_out   = rdn_q ? 8'h00 : rx_data_q;
   assign data_ready = ready_q;
   assign tbre       = tbre_q;
   assign tsre       = tsre_q;

endmodule
